// File: rtl/dest_fifo_drain.sv
// dest_fifo_drain: drains destination FIFOs D0/D1 into one valid/ready stream with per-source
// delivery counters and sticky error flags. Define DRAIN_STRICT_PRIO_EN for fixed D0 priority.
module dest_fifo_drain #(
  parameter int BW    = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic             D0_empty,
  input  logic             D0_error_output,
  input  logic [BW-1:0]    D0_data_out,
  input  logic             D1_empty,
  input  logic             D1_error_output,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D0_rd,
  output logic             D1_rd,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BW-1:0]    out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] D0_count,
  output logic [CNT_W-1:0] D1_count,
  output logic [1:0]       error_flags
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic             rd_prev_q, rd_prev_d;
  logic             src_q, src_d;
  logic             last_src_q, last_src_d;
  logic             out_valid_q, out_valid_d;
  logic [BW-1:0]    out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic [CNT_W-1:0] d0_count_q, d0_count_d;
  logic [CNT_W-1:0] d1_count_q, d1_count_d;
  logic [1:0]       error_flags_q, error_flags_d;
  logic             elig0, elig1, pick, issue, accept;
  logic             d0_rd_s, d1_rd_s;

  // Next-state: arbitration, read issue, capture/handshake, counters, FSM and error flags
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    rd_prev_d     = 1'b0;
    src_d         = src_q;
    last_src_d    = last_src_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    d0_count_d    = d0_count_q;
    d1_count_d    = d1_count_q;
    error_flags_d = error_flags_q;
    d0_rd_s       = 1'b0;
    d1_rd_s       = 1'b0;

    elig0  = ~D0_empty & ~D0_error_output & ~error_flags_q[0];
    elig1  = ~D1_empty & ~D1_error_output & ~error_flags_q[1];
    accept = out_valid_q & out_ready;
    issue  = (state_q == RUN) & init & ~pending_q & ~rd_prev_q
           & (~out_valid_q | out_ready) & (elig0 | elig1);

`ifdef DRAIN_STRICT_PRIO_EN
    pick = ~elig0;
`else
    if (elig0 && elig1) begin
      pick = ~last_src_q;
    end else begin
      pick = ~elig0;
    end
`endif

    if (issue) begin
      pending_d = 1'b1;
      rd_prev_d = 1'b1;
      src_d     = pick;
      d0_rd_s   = ~pick;
      d1_rd_s   = pick;
`ifndef DRAIN_STRICT_PRIO_EN
      last_src_d = pick;
`endif
    end else begin
      rd_prev_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b0;
      if (out_src_q) begin
        d1_count_d = d1_count_q + CNT_ONE;
      end else begin
        d0_count_d = d0_count_q + CNT_ONE;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    // Capture is evaluated after accept so a same-edge capture keeps out_valid high
    if (rd_prev_q) begin
      out_valid_d = 1'b1;
      out_data_d  = src_q ? D1_data_out : D0_data_out;
      out_src_d   = src_q;
      pending_d   = 1'b0;
    end else begin
      out_data_d  = out_data_q;
    end

    case (state_q)
      IDLE: begin
        if (init) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!init && !pending_q) begin
          state_d       = IDLE;
          error_flags_d = 2'b00;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    error_flags_d = error_flags_d | {D1_error_output, D0_error_output};
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      rd_prev_q     <= 1'b0;
      src_q         <= 1'b0;
      last_src_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= {BW{1'b0}};
      out_src_q     <= 1'b0;
      d0_count_q    <= {CNT_W{1'b0}};
      d1_count_q    <= {CNT_W{1'b0}};
      error_flags_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rd_prev_q     <= rd_prev_d;
      src_q         <= src_d;
      last_src_q    <= last_src_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      d0_count_q    <= d0_count_d;
      d1_count_q    <= d1_count_d;
      error_flags_q <= error_flags_d;
    end
  end

  assign D0_rd       = d0_rd_s;
  assign D1_rd       = d1_rd_s;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign D0_count    = d0_count_q;
  assign D1_count    = d1_count_q;
  assign error_flags = error_flags_q;

endmodule

// File: tb/tb_dest_fifo_drain.sv
// Bench for dest_fifo_drain: FIFO models for D0/D1, scoreboard of expected merged words,
// one task per scenario.
module tb_dest_fifo_drain;
  localparam int BW    = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_L, init, out_ready;
  logic             D0_empty, D0_error_output, D1_empty, D1_error_output;
  logic [BW-1:0]    D0_data_out, D1_data_out;
  logic             D0_rd, D1_rd, out_valid, out_src;
  logic [BW-1:0]    out_data;
  logic [CNT_W-1:0] D0_count, D1_count;
  logic [1:0]       error_flags;

  always #5 clk = ~clk;

  dest_fifo_drain #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .D0_empty(D0_empty), .D0_error_output(D0_error_output), .D0_data_out(D0_data_out),
    .D1_empty(D1_empty), .D1_error_output(D1_error_output), .D1_data_out(D1_data_out),
    .D0_rd(D0_rd), .D1_rd(D1_rd), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .D0_count(D0_count), .D1_count(D1_count),
    .error_flags(error_flags)
  );

  int            checks = 0;
  int            errors = 0;
  int            exp_cnt0 = 0;
  int            exp_cnt1 = 0;
  logic [BW-1:0] d0_fifo[$];
  logic [BW-1:0] d1_fifo[$];
  logic [BW:0]   sb[$];

  // FIFO model: data appears the cycle after a pop strobe; inputs change on negedge
  task automatic fifo_model();
    logic rd0_prev = 1'b0;
    logic rd1_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rd0_prev && d0_fifo.size() > 0) D0_data_out = d0_fifo.pop_front();
      if (rd1_prev && d1_fifo.size() > 0) D1_data_out = d1_fifo.pop_front();
      D0_empty = (d0_fifo.size() == 0);
      D1_empty = (d1_fifo.size() == 0);
      #3;
      rd0_prev = D0_rd;
      rd1_prev = D1_rd;
    end
  endtask

  task automatic run_monitor();
    logic [BW:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (reset_L && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL accept_unexpected: got src=%0d data=0x%02h, required no word", out_src, out_data);
        end else begin
          exp = sb.pop_front();
          if ({out_src, out_data} !== exp) begin
            errors++;
            $display("FAIL accept_word: got src=%0d data=0x%02h, required src=%0d data=0x%02h",
                     out_src, out_data, exp[BW], exp[BW-1:0]);
          end
        end
      end
    end
  endtask

  task automatic expect_word(input logic src, input logic [BW-1:0] d);
    sb.push_back({src, d});
    if (src) exp_cnt1++; else exp_cnt0++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_L = 1'b0;
    repeat (3) @(negedge clk);
    reset_L = 1'b1;
    sb.delete();
    exp_cnt0 = 0;
    exp_cnt1 = 0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < max_cyc) begin
      @(negedge clk);
      #2;
      if (!out_valid && !D0_rd && !D1_rd) idle++; else idle = 0;
      n++;
    end
    if (idle < 3) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    d0_fifo.push_back(6'h11);
    d1_fifo.push_back(6'h22);
    repeat (3) @(negedge clk);
    #2;
    checks++; if (D0_rd !== 1'b0) begin errors++; $display("FAIL reset_d0_rd: got %b required 0", D0_rd); end
    checks++; if (D1_rd !== 1'b0) begin errors++; $display("FAIL reset_d1_rd: got %b required 0", D1_rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 6'h00) begin errors++; $display("FAIL reset_out_data: got 0x%02h required 0x00", out_data); end
    checks++; if (D0_count !== 8'h00) begin errors++; $display("FAIL reset_d0_count: got %0d required 0", D0_count); end
    checks++; if (D1_count !== 8'h00) begin errors++; $display("FAIL reset_d1_count: got %0d required 0", D1_count); end
    checks++; if (error_flags !== 2'b00) begin errors++; $display("FAIL reset_error_flags: got %b required 00", error_flags); end
    d0_fifo.delete();
    d1_fifo.delete();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_single_stream();
    int r0[$];
    int outs[$];
    int d1_hits = 0;
    d0_fifo.push_back(6'h05); expect_word(1'b0, 6'h05);
    d0_fifo.push_back(6'h17); expect_word(1'b0, 6'h17);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    init = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #2;
      if (D0_rd) r0.push_back(c);
      if (D1_rd) d1_hits++;
      if (out_valid) outs.push_back(c);
      @(negedge clk);
    end
    checks++;
    if (r0.size() != 2 || outs.size() != 2) begin
      errors++;
      $display("FAIL single_counts: got %0d rd / %0d valid cycles, required 2 / 2", r0.size(), outs.size());
    end else begin
      checks++; if (r0[1] - r0[0] != 2) begin errors++; $display("FAIL single_rd_gap: got %0d required 2", r0[1] - r0[0]); end
      checks++; if (outs[0] - r0[0] != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", outs[0] - r0[0]); end
      checks++; if (outs[1] - r0[0] != 4) begin errors++; $display("FAIL single_second_out: got %0d required 4", outs[1] - r0[0]); end
    end
    checks++; if (d1_hits != 0) begin errors++; $display("FAIL single_d1_rd: got %0d required 0", d1_hits); end
    #2;
    checks++; if (D0_count !== 8'd2) begin errors++; $display("FAIL single_d0_count: got %0d required 2", D0_count); end
  endtask

  task automatic test_round_robin();
    logic [BW-1:0] a[3] = '{6'h21, 6'h32, 6'h03};
    logic [BW-1:0] b[3] = '{6'h3C, 6'h1A, 6'h2F};
    init = 1'b0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      d0_fifo.push_back(a[i]);
      d1_fifo.push_back(b[i]);
    end
`ifdef DRAIN_STRICT_PRIO_EN
    for (int i = 0; i < 3; i++) expect_word(1'b0, a[i]);
    for (int i = 0; i < 3; i++) expect_word(1'b1, b[i]);
`else
    for (int i = 0; i < 3; i++) begin
      expect_word(1'b0, a[i]);
      expect_word(1'b1, b[i]);
    end
`endif
    repeat (2) @(negedge clk);
    init = 1'b1;
    wait_drain(100, "rr");
    checks++; if (D0_count !== 8'd3) begin errors++; $display("FAIL rr_d0_count: got %0d required 3", D0_count); end
    checks++; if (D1_count !== 8'd3) begin errors++; $display("FAIL rr_d1_count: got %0d required 3", D1_count); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_leftover: got %0d words pending, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int bad = 0;
    @(negedge clk);
    out_ready = 1'b0;
    d0_fifo.push_back(6'h26); expect_word(1'b0, 6'h26);
    d0_fifo.push_back(6'h11); expect_word(1'b0, 6'h11);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_no_valid: got out_valid=0 after 20 cycles, required 1");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (out_valid !== 1'b1 || out_data !== 6'h26 || out_src !== 1'b0 || D0_rd || D1_rd) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles, required 0 (data 0x%02h)", bad, out_data); end
    @(negedge clk);
    out_ready = 1'b1;
    #2;
    checks++; if (D0_rd !== 1'b1) begin errors++; $display("FAIL bp_release_rd: got %b required 1", D0_rd); end
    wait_drain(40, "bp");
    checks++; if (D0_count !== exp_cnt0[CNT_W-1:0]) begin errors++; $display("FAIL bp_d0_count: got %0d required %0d", D0_count, exp_cnt0); end
  endtask

  task automatic test_error_mask();
    int d1_hits = 0;
    @(negedge clk);
    D1_error_output = 1'b1;
    @(negedge clk);
    D1_error_output = 1'b0;
    #2;
    checks++; if (error_flags !== 2'b10) begin errors++; $display("FAIL err_set: got %b required 10", error_flags); end
    d0_fifo.push_back(6'h0A); expect_word(1'b0, 6'h0A);
    d0_fifo.push_back(6'h0B); expect_word(1'b0, 6'h0B);
    d1_fifo.push_back(6'h31);
    d1_fifo.push_back(6'h32);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #2;
      if (D1_rd) d1_hits++;
    end
    checks++; if (d1_hits != 0) begin errors++; $display("FAIL err_d1_masked: got %0d D1 reads required 0", d1_hits); end
    checks++; if (error_flags !== 2'b10) begin errors++; $display("FAIL err_sticky: got %b required 10", error_flags); end
    checks++; if (d1_fifo.size() != 2) begin errors++; $display("FAIL err_d1_left: got %0d required 2", d1_fifo.size()); end
    checks++; if (D0_count !== exp_cnt0[CNT_W-1:0]) begin errors++; $display("FAIL err_d0_count: got %0d required %0d", D0_count, exp_cnt0); end
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    #2;
    checks++; if (error_flags !== 2'b00) begin errors++; $display("FAIL err_clear: got %b required 00", error_flags); end
    expect_word(1'b1, 6'h31);
    expect_word(1'b1, 6'h32);
    @(negedge clk);
    init = 1'b1;
    wait_drain(60, "err");
    checks++; if (d1_fifo.size() != 0) begin errors++; $display("FAIL err_d1_drained: got %0d left required 0", d1_fifo.size()); end
    checks++; if (D1_count !== exp_cnt1[CNT_W-1:0]) begin errors++; $display("FAIL err_d1_count: got %0d required %0d", D1_count, exp_cnt1); end
  endtask

  task automatic test_counter_wrap();
    logic [BW-1:0] w;
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      w = i[BW-1:0];
      d0_fifo.push_back(w);
      expect_word(1'b0, w);
    end
    wait_drain(1500, "wrap");
    checks++; if (D0_count !== 8'hFF) begin errors++; $display("FAIL wrap_max: got 0x%02h required 0xFF", D0_count); end
    d0_fifo.push_back(6'h3F);
    expect_word(1'b0, 6'h3F);
    wait_drain(40, "wrap2");
    checks++; if (D0_count !== 8'h00) begin errors++; $display("FAIL wrap_zero: got 0x%02h required 0x00", D0_count); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_leftover: got %0d required 0", sb.size()); end
  endtask

  initial begin
    reset_L         = 1'b0;
    init            = 1'b0;
    out_ready       = 1'b0;
    D0_empty        = 1'b1;
    D1_empty        = 1'b1;
    D0_error_output = 1'b0;
    D1_error_output = 1'b0;
    D0_data_out     = 6'h00;
    D1_data_out     = 6'h00;
    fork
      fifo_model();
      run_monitor();
    join_none
    test_reset();
    test_single_stream();
    test_round_robin();
    test_backpressure();
    test_error_mask();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
